operand_loader: RTL and testbench

- Front-end input stage of the DE10-Lite virtual board ALU path.
- Turns raw slide-switch and push-button inputs into registered 8-bit operands A and B, loaded one nibble at a time.
- Drives the seven-segment driver stage (arg, select_args, lo_hi_arg, load_args, operand_a, operand_b) and the ALU operand inputs.
- Provides 2-FF synchronisation, per-button debounce, rising-edge event detection and a small selection/load state machine.

---
 rtl/operand_loader.sv | 85 ++++++++
 tb/tb_operand_loader.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/operand_loader.sv
// operand_loader: synchronises and debounces board buttons, then loads 8-bit operands A and B one nibble at a time.
module operand_loader #(
  parameter int OPERAND_DESIGN  = 3,
  parameter int RESULT_DESIGN   = 7,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [OPERAND_DESIGN:0]   sw_arg,
  input  logic                      btn_select,
  input  logic                      btn_lo_hi,
  input  logic                      btn_load,
  output logic [OPERAND_DESIGN:0]   arg,
  output logic                      select_args,
  output logic                      lo_hi_arg,
  output logic                      load_args,
  output logic [RESULT_DESIGN:0]    operand_a,
  output logic [RESULT_DESIGN:0]    operand_b,
  output logic                      operands_ready
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [OPERAND_DESIGN:0] r_sw1, r_sw2;
  logic [2:0] r_btn1, r_btn2, r_db, r_db_d, r_evt;
  logic [CW-1:0] r_cnt [3];
  logic r_sel, r_lh, r_load, r_ready;
  logic [3:0] r_mask;
  logic [RESULT_DESIGN:0] r_a, r_b, w_src, w_wr;
  // button bit order: 0 = select, 1 = lo/hi, 2 = load
  assign w_src = r_sel ? r_b : r_a;
  assign w_wr  = r_lh ? {r_sw2, w_src[OPERAND_DESIGN:0]}
                      : {w_src[RESULT_DESIGN:OPERAND_DESIGN+1], r_sw2};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sw1  <= '0;
      r_sw2  <= '0;
      r_btn1 <= '0;
      r_btn2 <= '0;
      r_db   <= '0;
      r_db_d <= '0;
      r_evt  <= '0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      r_sw1  <= sw_arg;
      r_sw2  <= r_sw1;
      r_btn1 <= {btn_load, btn_lo_hi, btn_select};
      r_btn2 <= r_btn1;
      r_db_d <= r_db;
      r_evt  <= r_db & ~r_db_d;
      for (int i = 0; i < 3; i++)
        if (r_btn2[i] == r_db[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == MAX) begin
          r_db[i]  <= r_btn2[i];
          r_cnt[i] <= '0;
        end else r_cnt[i] <= r_cnt[i] + CW'(1);
    end
  // a load uses the pre-toggle selection even when toggles fire on the same edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sel   <= 1'b0;
      r_lh    <= 1'b0;
      r_load  <= 1'b0;
      r_ready <= 1'b0;
      r_mask  <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_load  <= r_evt[2];
      r_ready <= &r_mask;
      if (r_evt[0]) r_sel <= ~r_sel;
      if (r_evt[1]) r_lh <= ~r_lh;
      if (r_evt[2]) begin
        if (r_sel) r_b <= w_wr;
        else r_a <= w_wr;
        r_mask[{r_sel, r_lh}] <= 1'b1;
      end
    end
  assign arg            = r_sw2;
  assign select_args    = r_sel;
  assign lo_hi_arg      = r_lh;
  assign load_args      = r_load;
  assign operand_a      = r_a;
  assign operand_b      = r_b;
  assign operands_ready = r_ready;
endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: directed stimulus against a delay/window reference model of the operand loader.
module tb_operand_loader;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] sw_arg = '0;
  logic btn_select = 1'b0, btn_lo_hi = 1'b0, btn_load = 1'b0;
  logic [3:0] arg;
  logic select_args, lo_hi_arg, load_args, operands_ready;
  logic [7:0] operand_a, operand_b;
  int checks = 0, failures = 0, loads = 0;
  logic on = 1'b0;
  always #5 clk = ~clk;
  operand_loader #(.OPERAND_DESIGN(3), .RESULT_DESIGN(7), .DEBOUNCE_CYCLES(N)) dut (
    .clk(clk), .rst(rst), .sw_arg(sw_arg),
    .btn_select(btn_select), .btn_lo_hi(btn_lo_hi), .btn_load(btn_load),
    .arg(arg), .select_args(select_args), .lo_hi_arg(lo_hi_arg), .load_args(load_args),
    .operand_a(operand_a), .operand_b(operand_b), .operands_ready(operands_ready)
  );
  // model: raw sample history; a button's accepted state flips once the last N
  // synchronised samples all disagree with it; its action lands two edges later
  logic [2:0] h [N+2];
  logic [3:0] m_sw, m_arg, m_mask;
  logic [2:0] m_db, m_rise1, m_rise2, m_new;
  logic m_sel, m_lh, m_load, m_ready;
  logic [7:0] m_a, m_b;
  task automatic model_clear();
    foreach (h[i]) h[i] = '0;
    {m_sw, m_arg, m_mask, m_db, m_rise1, m_rise2} = '0;
    {m_sel, m_lh, m_load, m_ready, m_a, m_b} = '0;
  endtask
  task automatic model_step();
    logic all_diff;
    m_ready = &m_mask;
    m_load  = m_rise2[2];
    if (m_rise2[2]) begin
      if (m_sel) m_b = m_lh ? {m_arg, m_b[3:0]} : {m_b[7:4], m_arg};
      else m_a = m_lh ? {m_arg, m_a[3:0]} : {m_a[7:4], m_arg};
      m_mask[{m_sel, m_lh}] = 1'b1;
    end
    if (m_rise2[0]) m_sel = ~m_sel;
    if (m_rise2[1]) m_lh = ~m_lh;
    m_arg = m_sw;
    m_sw  = sw_arg;
    for (int i = N + 1; i > 0; i--) h[i] = h[i-1];
    h[0] = {btn_load, btn_lo_hi, btn_select};
    m_new = '0;
    for (int b = 0; b < 3; b++) begin
      all_diff = 1'b1;
      for (int k = 2; k < N + 2; k++) if (h[k][b] == m_db[b]) all_diff = 1'b0;
      if (all_diff) begin
        m_db[b]  = ~m_db[b];
        m_new[b] = m_db[b];
      end
    end
    m_rise2 = m_rise1;
    m_rise1 = m_new;
  endtask
  always @(posedge clk or posedge rst)
    if (rst) model_clear();
    else model_step();
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (load_args) loads++;
    if (on) begin
      chk("arg", arg, m_arg);
      chk("select_args", select_args, m_sel);
      chk("lo_hi_arg", lo_hi_arg, m_lh);
      chk("load_args", load_args, m_load);
      chk("operand_a", operand_a, m_a);
      chk("operand_b", operand_b, m_b);
      chk("operands_ready", operands_ready, m_ready);
    end
  end
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_arg", arg, 0);
    chk("rst_sel", select_args, 0);
    chk("rst_lohi", lo_hi_arg, 0);
    chk("rst_load", load_args, 0);
    chk("rst_a", operand_a, 0);
    chk("rst_b", operand_b, 0);
    chk("rst_ready", operands_ready, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic press(logic [2:0] b, int n);
    @(negedge clk);
    {btn_load, btn_lo_hi, btn_select} = b;
    cyc(n);
    {btn_load, btn_lo_hi, btn_select} = '0;
    cyc(12);
  endtask
  initial begin
    cyc(1);
    do_reset();
    on = 1'b1;
    sw_arg = 4'hA;
    loads = 0;
    press(3'b100, 10);
    chk("basic_pulses", loads, 1);
    chk("basic_a", operand_a, 8'h0A);
    chk("basic_b", operand_b, 8'h00);
    loads = 0;
    sw_arg = 4'h6;
    btn_load = 1'b1;
    cyc(1);
    btn_load = 1'b0;
    cyc(1);
    btn_load = 1'b1;
    cyc(1);
    btn_load = 1'b0;
    cyc(15);
    chk("bounce_pulses", loads, 0);
    chk("bounce_a", operand_a, 8'h0A);
    loads = 0;
    press(3'b100, 50);
    chk("hold_pulses", loads, 1);
    chk("hold_a", operand_a, 8'h06);
    sw_arg = 4'($urandom);
    {btn_load, btn_lo_hi, btn_select} = 3'($urandom);
    do_reset();
    {btn_load, btn_lo_hi, btn_select} = '0;
    cyc(12);
    sw_arg = 4'h5;
    press(3'b100, 10);
    press(3'b010, 10);
    sw_arg = 4'hC;
    press(3'b100, 10);
    press(3'b001, 10);
    sw_arg = 4'h3;
    press(3'b100, 10);
    press(3'b010, 10);
    sw_arg = 4'hF;
    chk("seq_ready_before", operands_ready, 0);
    press(3'b100, 10);
    chk("seq_a", operand_a, 8'hC5);
    chk("seq_b", operand_b, 8'h3F);
    chk("seq_ready_after", operands_ready, 1);
    chk("seq_sel", select_args, 1);
    do_reset();
    sw_arg = 4'h7;
    loads = 0;
    press(3'b101, 10);
    chk("simul_a", operand_a, 8'h07);
    chk("simul_b", operand_b, 8'h00);
    chk("simul_sel", select_args, 1);
    chk("simul_pulses", loads, 1);
    do_reset();
    sw_arg = 4'h9;
    cyc(2);
    loads = 0;
    btn_load = 1'b1;
    cyc(4);
    do_reset();
    chk("midrst_pulses", loads, 0);
    chk("midrst_a", operand_a, 8'h00);
    cyc(12);
    chk("after_rst_pulses", loads, 1);
    chk("after_rst_a", operand_a, 8'h09);
    btn_load = 1'b0;
    cyc(12);
    chk("release_pulses", loads, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
